// File: rtl/cia_coeff_pkg.sv
// ----------------------------------------------------------------------------
// cia_coeff_pkg
// Shared constants and the state encoding for the coefficient modular reducer.
//   DEPTH : coefficients per polynomial frame
//   IN_W  : width of the raw coefficient sum from the b-adder
//   Q     : modulus; QW is the width of a reduced coefficient
//   IDX_W : width of a coefficient index
// ----------------------------------------------------------------------------
package cia_coeff_pkg;

    localparam int DEPTH = 100;
    localparam int IN_W  = 36;
    localparam int Q     = 12289;
    localparam int QW    = $clog2(Q);
    localparam int IDX_W = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        FIX    = 2'd2,
        OUT    = 2'd3
    } red_state_t;

endpackage

// File: rtl/coeff_mod_reducer_cond_sub_step.sv
// ----------------------------------------------------------------------------
// cond_sub_step
// One restoring-division step: subtract the shifted modulus when it fits.
//   i_r  : current remainder
//   i_qk : modulus shifted left by the current step count
//   o_r  : i_r - i_qk when i_r >= i_qk, otherwise i_r unchanged
// Purely combinational; the full width is kept so nothing is truncated.
// ----------------------------------------------------------------------------
module cond_sub_step #(
    parameter int W = 37
) (
    input  logic [W-1:0] i_r,
    input  logic [W-1:0] i_qk,
    output logic [W-1:0] o_r
);

    assign o_r = (i_r >= i_qk) ? (i_r - i_qk) : i_r;

endmodule

// File: rtl/coeff_mod_reducer.sv
// ----------------------------------------------------------------------------
// coeff_mod_reducer
// Takes one raw coefficient sum per handshake from the b-adder, reduces it
// modulo Q into [0, Q-1] and offers it downstream with its index. Indices are
// expected in order 0..DEPTH-1; a mismatch raises a sticky error flag, and the
// handoff of index DEPTH-1 pulses frame_done.
//
// Ports
//   clk_in, rst_in        clock, asynchronous active-high reset
//   sum_valid/sum_ready   input handshake (transfer when both high at clk edge)
//   sum, sum_idx          raw sum and its coefficient index
//   coeff_valid/ready     output handshake (transfer when both high at clk edge)
//   coeff, coeff_idx      reduced coefficient and its index
//   frame_done            one-cycle pulse after index DEPTH-1 is handed off
//   idx_err               sticky index-order error
//   dbg_state             current FSM state
//
// Handshakes: a word moves on a rising edge where valid and ready are both
// high. The producer holds data stable while valid is high and ready is low;
// valid never drops without a transfer.
//
// Flow: IDLE -> REDUCE (IN_W-QW+1 cycles) -> FIX -> OUT -> IDLE. Only one
// coefficient is in flight, so sum_ready is high only in IDLE.
// ----------------------------------------------------------------------------
module coeff_mod_reducer #(
    parameter int DEPTH     = cia_coeff_pkg::DEPTH,
    parameter int IN_W      = cia_coeff_pkg::IN_W,
    parameter int Q         = cia_coeff_pkg::Q,
    parameter bit SIGNED_IN = 1'b1,
    localparam int QW       = $clog2(Q)
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            sum_valid,
    input  logic [IN_W-1:0] sum,
    input  logic [9:0]      sum_idx,
    output logic            sum_ready,
    output logic            coeff_valid,
    output logic [QW-1:0]   coeff,
    output logic [9:0]      coeff_idx,
    input  logic            coeff_ready,
    output logic            frame_done,
    output logic            idx_err,
    output logic [1:0]      dbg_state
);

    import cia_coeff_pkg::*;

    // One extra bit of headroom so Q<<k and the remainder never wrap.
    localparam int            RW       = IN_W + 1;
    localparam int            K_MAX    = IN_W - QW;
    localparam int            KW       = $clog2(K_MAX + 1);
    localparam logic [RW-1:0] Q_RW     = RW'(Q);
    localparam logic [9:0]    LAST_IDX = 10'(DEPTH - 1);

    red_state_t      r_state;
    logic [RW-1:0]   r_rem;
    logic            r_sign;
    logic [9:0]      r_idx;
    logic [9:0]      r_exp_idx;
    logic [KW-1:0]   r_k;
    logic            r_sum_ready;
    logic            r_coeff_valid;
    logic [QW-1:0]   r_coeff;
    logic [9:0]      r_coeff_idx;
    logic            r_frame_done;
    logic            r_idx_err;

    logic            w_neg;
    logic [IN_W-1:0] w_mag;
    logic [RW-1:0]   w_qk;
    logic [RW-1:0]   w_rem_next;
    logic [QW-1:0]   w_fixed;
    logic            w_accept;

    // Magnitude of the input; the most negative value negates to 2^(IN_W-1),
    // which is still representable as an unsigned IN_W-bit number.
    assign w_neg = SIGNED_IN && sum[IN_W-1];
    assign w_mag = w_neg ? (~sum + 1'b1) : sum;

    assign w_qk = Q_RW << r_k;

    cond_sub_step #(
        .W(RW)
    ) u_step (
        .i_r (r_rem),
        .i_qk(w_qk),
        .o_r (w_rem_next)
    );

    // After REDUCE the remainder is below Q, so Q - r fits in QW bits. A zero
    // remainder of a negative input stays zero rather than becoming Q.
    assign w_fixed = (r_sign && (r_rem != '0)) ? QW'(Q_RW - r_rem) : r_rem[QW-1:0];

    // r_sum_ready is only ever high in IDLE.
    assign w_accept = sum_valid && r_sum_ready;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state       <= IDLE;
            r_rem         <= '0;
            r_sign        <= 1'b0;
            r_idx         <= '0;
            r_exp_idx     <= '0;
            r_k           <= '0;
            r_sum_ready   <= 1'b0;
            r_coeff_valid <= 1'b0;
            r_coeff       <= '0;
            r_coeff_idx   <= '0;
            r_frame_done  <= 1'b0;
            r_idx_err     <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_sum_ready <= 1'b1;
                    if (w_accept) begin
                        r_sum_ready <= 1'b0;
                        r_rem       <= {1'b0, w_mag};
                        r_sign      <= w_neg;
                        r_idx       <= sum_idx;
                        r_k         <= KW'(K_MAX);
                        if (sum_idx != r_exp_idx) begin
                            r_idx_err <= 1'b1;
                        end
                        // Resync to the received index; out-of-range also wraps.
                        r_exp_idx   <= (sum_idx >= LAST_IDX) ? 10'd0 : (sum_idx + 10'd1);
                        r_state     <= REDUCE;
                    end
                end
                REDUCE: begin
                    r_rem <= w_rem_next;
                    if (r_k == '0) begin
                        r_state <= FIX;
                    end else begin
                        r_k <= r_k - 1'b1;
                    end
                end
                FIX: begin
                    r_coeff       <= w_fixed;
                    r_coeff_idx   <= r_idx;
                    r_coeff_valid <= 1'b1;
                    r_state       <= OUT;
                end
                OUT: begin
                    if (coeff_ready) begin
                        r_coeff_valid <= 1'b0;
                        r_frame_done  <= (r_coeff_idx == LAST_IDX);
                        r_sum_ready   <= 1'b1;
                        r_state       <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign sum_ready   = r_sum_ready;
    assign coeff_valid = r_coeff_valid;
    assign coeff       = r_coeff;
    assign coeff_idx   = r_coeff_idx;
    assign frame_done  = r_frame_done;
    assign idx_err     = r_idx_err;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_coeff_mod_reducer.sv
// ----------------------------------------------------------------------------
// tb_coeff_mod_reducer
// Two reducers share one stimulus stream: one treats sums as signed, the
// other as unsigned. Expected results are hand-computed and queued when a sum
// is issued; per-instance monitors pop and compare at each output handoff.
// ----------------------------------------------------------------------------
module tb_coeff_mod_reducer;
    import cia_coeff_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- stimulus and DUT signals ----------------
    logic        sum_valid   = 1'b0;
    logic [35:0] sum         = '0;
    logic [9:0]  sum_idx     = '0;
    logic        coeff_ready = 1'b1;

    logic        sum_ready_s, coeff_valid_s, frame_done_s, idx_err_s;
    logic [13:0] coeff_s;
    logic [9:0]  coeff_idx_s;
    logic [1:0]  dbg_state_s;
    logic        sum_ready_u, coeff_valid_u, frame_done_u, idx_err_u;
    logic [13:0] coeff_u;
    logic [9:0]  coeff_idx_u;
    logic [1:0]  dbg_state_u;

    coeff_mod_reducer #(.SIGNED_IN(1'b1)) u_dut_s (
        .clk_in(clk), .rst_in(rst), .sum_valid(sum_valid), .sum(sum), .sum_idx(sum_idx),
        .sum_ready(sum_ready_s), .coeff_valid(coeff_valid_s), .coeff(coeff_s),
        .coeff_idx(coeff_idx_s), .coeff_ready(coeff_ready), .frame_done(frame_done_s),
        .idx_err(idx_err_s), .dbg_state(dbg_state_s)
    );

    coeff_mod_reducer #(.SIGNED_IN(1'b0)) u_dut_u (
        .clk_in(clk), .rst_in(rst), .sum_valid(sum_valid), .sum(sum), .sum_idx(sum_idx),
        .sum_ready(sum_ready_u), .coeff_valid(coeff_valid_u), .coeff(coeff_u),
        .coeff_idx(coeff_idx_u), .coeff_ready(coeff_ready), .frame_done(frame_done_u),
        .idx_err(idx_err_u), .dbg_state(dbg_state_u)
    );

    // ---------------- scoreboard ----------------
    int          n_checks  = 0;
    int          n_errors  = 0;
    int          frame_cnt = 0;
    logic [23:0] exp_s_q[$];   // {idx, coeff} expected from the signed instance
    logic [23:0] exp_u_q[$];   // {idx, coeff} expected from the unsigned instance
    logic [23:0] e_s, e_u;
    logic [9:0]  last_idx_s = '0;
    bit          b_done = 1'b0;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", name, act, act, req, req, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    always @(negedge clk) begin
        if (!rst && coeff_valid_s && coeff_ready) begin
            if (exp_s_q.size() == 0) begin
                timeout_fail("mon_s_unexpected_output");
            end else begin
                e_s = exp_s_q.pop_front();
                check("coeff_s {idx,coeff}", {coeff_idx_s, coeff_s}, e_s);
                last_idx_s = coeff_idx_s;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && coeff_valid_u && coeff_ready) begin
            if (exp_u_q.size() == 0) begin
                timeout_fail("mon_u_unexpected_output");
            end else begin
                e_u = exp_u_q.pop_front();
                check("coeff_u {idx,coeff}", {coeff_idx_u, coeff_u}, e_u);
            end
        end
    end

    // frame_done must follow the handoff of index DEPTH-1.
    always @(negedge clk) begin
        if (!rst && frame_done_s) begin
            frame_cnt++;
            check("frame_done_after_idx", last_idx_s, DEPTH - 1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [35:0] s, input logic [9:0] idx,
                        input logic [13:0] es, input logic [13:0] eu, input bit push);
        int t;
        t = 0;
        sum_valid = 1'b1;
        sum       = s;
        sum_idx   = idx;
        if (push) begin
            exp_s_q.push_back({idx, es});
            exp_u_q.push_back({idx, eu});
        end
        while (1) begin
            @(negedge clk);
            if (sum_ready_s) break;
            t++;
            if (t > 200) begin
                timeout_fail("send_accept");
                break;
            end
        end
        @(posedge clk);
        #1;
        sum_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_s_q.size() != 0 || exp_u_q.size() != 0) && t < 500) begin
            @(posedge clk);
            t++;
        end
        if (t >= 500) timeout_fail("drain");
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            send(36'(i * 123), 10'(i), 14'(i * 123), 14'(i * 123), 1'b1);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int t;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sum_ready", sum_ready_s, 0);
        check("rst_coeff_valid", coeff_valid_s, 0);
        check("rst_coeff", coeff_s, 0);
        check("rst_coeff_idx", coeff_idx_s, 0);
        check("rst_frame_done", frame_done_s, 0);
        check("rst_idx_err", idx_err_s, 0);
        check("rst_state", dbg_state_s, IDLE);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("ready_after_reset", sum_ready_s, 1);

        // Latency: accept edge to coeff_valid high
        send(36'd25000, 10'd0, 14'd422, 14'd422, 1'b1);
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (coeff_valid_s) break;
        end
        check("latency_cycles", n, 24);
        wait_drain();

        // Directed values (signed expectation, unsigned expectation)
        send(36'd12289,          10'd1, 14'd0,     14'd0,     1'b1);
        send(36'd1048576,        10'd2, 14'd4011,  14'd4011,  1'b1);
        send(36'd12288,          10'd3, 14'd12288, 14'd12288, 1'b1);
        send(36'hF_FFFF_FFFF,    10'd4, 14'd12288, 14'd3185,  1'b1); // -1
        send(36'hF_FFFF_CFFF,    10'd5, 14'd0,     14'd3186,  1'b1); // -12289
        send(36'h8_0000_0000,    10'd6, 14'd10696, 14'd1593,  1'b1); // -2^35
        wait_drain();

        // Back-pressure: output held 5 cycles while the next sum waits upstream
        coeff_ready = 1'b0;
        send(36'd30000, 10'd7, 14'd5422, 14'd5422, 1'b1);
        fork
            begin
                send(36'd100, 10'd8, 14'd100, 14'd100, 1'b1);
                b_done = 1'b1;
            end
        join_none
        t = 0;
        while (!coeff_valid_s && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 100) timeout_fail("bp_coeff_valid");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_coeff_stable", coeff_s, 5422);
            check("bp_idx_stable", coeff_idx_s, 7);
            check("bp_valid_held", coeff_valid_s, 1);
            check("bp_sum_ready_low", sum_ready_s, 0);
        end
        coeff_ready = 1'b1;
        t = 0;
        while (!b_done && t < 200) begin
            @(posedge clk);
            t++;
        end
        if (!b_done) timeout_fail("bp_held_sum");
        wait_drain();

        // Complete frame 1 (idx 9..99), then a full second frame
        send_frame(9, 99);
        wait_drain();
        check("frame1_count", frame_cnt, 1);
        check("frame1_idx_err", idx_err_s, 0);
        send_frame(0, 99);
        wait_drain();
        check("frame2_count", frame_cnt, 2);
        check("frame2_idx_err", idx_err_s, 0);

        // Out-of-order index: 5 arrives while 4 is expected
        send_frame(0, 3);
        wait_drain();
        check("pre_skip_idx_err", idx_err_s, 0);
        send(36'd615, 10'd5, 14'd615, 14'd615, 1'b1);
        check("skip_idx_err", idx_err_s, 1);
        send(36'd738, 10'd6, 14'd738, 14'd738, 1'b1);
        wait_drain();
        check("idx_err_sticky", idx_err_s, 1);
        check("idx_err_sticky_u", idx_err_u, 1);

        // Asynchronous reset in the middle of REDUCE
        send(36'd777, 10'd7, 14'd0, 14'd0, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_coeff_valid", coeff_valid_s, 0);
        check("mid_rst_coeff", coeff_s, 0);
        check("mid_rst_coeff_idx", coeff_idx_s, 0);
        check("mid_rst_idx_err", idx_err_s, 0);
        check("mid_rst_sum_ready", sum_ready_s, 0);
        check("mid_rst_frame_done", frame_done_s, 0);
        check("mid_rst_state", dbg_state_s, IDLE);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send(36'd25000, 10'd0, 14'd422, 14'd422, 1'b1);
        wait_drain();
        check("post_rst_idx_err", idx_err_s, 0);
        check("post_rst_frame_count", frame_cnt, 2);
        check("final_queue_s_empty", exp_s_q.size(), 0);
        check("final_queue_u_empty", exp_u_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
